// File: rtl/data_sram_if.sv
// data_sram_if: SRAM-like data port between the pipeline (master) and the memory
// responder (slave).
//   req/wr/wstrb/addr/wdata : request from the pipeline
//   addr_ok                 : request accepted when req && addr_ok at a rising edge
//   data_ok/rdata           : in-order one-cycle response pulse and load data
interface data_sram_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side responder for the CPU data SRAM-like port.
// Accepts loads/stores, queues them in order and answers each one LATENCY cycles
// after acceptance. Owns the 2^ADDR_W x 32-bit storage and applies byte strobes
// at retirement, so a load queued behind a store to the same word sees its data.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high; flushes the queue, storage is kept
//   bus    - data_sram_if.slave (req, wr, wstrb, addr, wdata / addr_ok, data_ok, rdata)
//
// Optional build macro: DSRAM_RAND_STALL_EN adds a 16-bit LFSR that randomly
// forces addr_ok low to stress pipeline backpressure.
module data_sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,  // 1..7
    parameter int unsigned DEPTH   = 4   // power of two, 2..8
) (
    input logic        clk,
    input logic        reset,
    data_sram_if.slave bus
);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam logic [2:0]  AGE_MAX = 3'(LATENCY);
    localparam logic [2:0]  AGE_DUE = 3'(LATENCY - 1);

    typedef struct packed {
        logic              wr;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       wdata;
    } entry_t;

    entry_t           q_entry [DEPTH];
    logic [2:0]       q_age   [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             data_ok_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem [2**ADDR_W];

    entry_t     in_entry;
    entry_t     ret_entry;
    logic       accept;
    logic       retire;
    logic       bypass;
    logic       push;
    logic       pop;
    logic       stall;
    logic [2:0] head_age_now;

    // Only the word index is decoded; remaining address bits alias.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Registered occupancy only: no path from req or from same-cycle retirement.
    assign bus.addr_ok = (count_q != CNT_W'(DEPTH)) && !stall;
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    always_comb begin
        in_entry     = '{wr: bus.wr, wstrb: bus.wstrb, idx: bus.addr[ADDR_W+1:2],
                         wdata: bus.wdata};
        accept       = bus.req && bus.addr_ok;
        // Age the head entry will have at this edge (saturating).
        head_age_now = (q_age[head_q] == AGE_MAX) ? AGE_MAX : q_age[head_q] + 3'd1;
        retire       = 1'b0;
        bypass       = 1'b0;
        ret_entry    = q_entry[head_q];
        if (count_q != '0) begin
            retire = (head_age_now >= AGE_DUE);
        end else if (LATENCY == 1) begin
            // A new request is already due at its acceptance edge: serve it directly.
            bypass    = accept;
            retire    = accept;
            ret_entry = in_entry;
        end
        push = accept && !bypass;
        pop  = retire && !bypass;
    end

    // Queue control and response flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            data_ok_q <= retire;
            rdata_q   <= (retire && !ret_entry.wr) ? mem[ret_entry.idx] : 32'h0;
        end
    end

    // Queue payload; ages only matter for occupied slots, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_age[i] != AGE_MAX) begin
                q_age[i] <= q_age[i] + 3'd1;
            end
        end
        if (push) begin
            q_entry[tail_q] <= in_entry;
            q_age[tail_q]   <= 3'd0;
        end
    end

    // Storage: stores commit at retirement; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && retire && ret_entry.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (ret_entry.wstrb[i]) begin
                    mem[ret_entry.idx][8*i +: 8] <= ret_entry.wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
